cpu_run_ctrl: RTL and testbench

- Run/step/debug sequencer for the 5-stage pipelined CPU core. It generates the core's `enable`, `start` and a core reset, driven by a host command channel.
- Provides RUN (free-running), STEP(n) (exactly n execute cycles), STOP, and RESET commands, plus a PC breakpoint and halt detection.
- Sits between the board/host debug logic and the CPU. It observes only the CPU instruction address (`i_addr`).

---
 rtl/cpu_run_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/debug sequencer driving CPU enable, start and reset
// Host commands launch free runs or n-cycle steps; PC breakpoint and halt detection end them.
module cpu_run_ctrl #(
  parameter int HALT_CYC = 4,
  parameter int RST_CYC  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_count,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  cpu_i_addr,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_cause,
  output logic        cmd_err,
  output logic [31:0] cycle_cnt
);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [1:0] CAUSE_STEP = 2'd0;
  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_HALT = 2'd2;
  localparam logic [1:0] CAUSE_STOP = 2'd3;

  localparam logic [16:0] HALT_THR = 17'(HALT_CYC);
  localparam logic [15:0] RST_LD   = 16'(RST_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_LAUNCH,
    S_RUN,
    S_STEP
  } state_t;

  state_t      state_q;
  logic        mode_step_q;
  logic [15:0] remain_q;
  logic [15:0] rst_cnt_q;
  logic [7:0]  prev_pc_q;
  logic [15:0] same_cnt_q;
  logic        first_q;
  logic        done_q;
  logic [1:0]  done_cause_q;
  logic        cmd_err_q;
  logic [31:0] cycle_cnt_q;

  logic        in_exec;
  logic        pc_same;
  logic        stop_cmd;
  logic        bp_hit;
  logic        halt_hit;
  logic        step_done;
  logic        stop;
  logic [1:0]  stop_cause;
  logic [15:0] same_cnt_d;
  logic [15:0] step_len_d;

  assign in_exec   = (state_q == S_RUN) || (state_q == S_STEP);
  assign pc_same   = (cpu_i_addr == prev_pc_q);
  assign stop_cmd  = cmd_valid && (cmd_op == OP_STOP);
  // The first exec cycle is exempt so a resume from the breakpoint PC makes progress.
  assign bp_hit    = bp_en && (cpu_i_addr == bp_addr) && !first_q;
  assign halt_hit  = pc_same && (({1'b0, same_cnt_q} + 17'd1) >= HALT_THR);
  assign step_done = (state_q == S_STEP) && (remain_q == 16'd1);
  assign stop      = in_exec && (stop_cmd || bp_hit || halt_hit || step_done);

  always_comb begin
    stop_cause = CAUSE_STEP;
    if (stop_cmd)      stop_cause = CAUSE_STOP;
    else if (bp_hit)   stop_cause = CAUSE_BP;
    else if (halt_hit) stop_cause = CAUSE_HALT;
  end

  always_comb begin
    same_cnt_d = 16'd0;
    if (pc_same) begin
      same_cnt_d = (same_cnt_q == 16'hFFFF) ? same_cnt_q : same_cnt_q + 16'd1;
    end
  end

  assign step_len_d = (cmd_count == 16'd0) ? 16'd1 : cmd_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_step_q  <= 1'b0;
      remain_q     <= 16'd0;
      rst_cnt_q    <= 16'd0;
      prev_pc_q    <= 8'd0;
      same_cnt_q   <= 16'd0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
      done_cause_q <= CAUSE_STEP;
      cmd_err_q    <= 1'b0;
      cycle_cnt_q  <= 32'd0;
    end else begin
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_RESET: begin
                state_q   <= S_CRST;
                rst_cnt_q <= RST_LD;
              end
              OP_RUN: begin
                state_q     <= S_LAUNCH;
                mode_step_q <= 1'b0;
              end
              OP_STEP: begin
                state_q     <= S_LAUNCH;
                mode_step_q <= 1'b1;
                remain_q    <= step_len_d;
              end
              default: ;
            endcase
          end
        end
        S_CRST: begin
          if (cmd_valid) cmd_err_q <= 1'b1;
          if (rst_cnt_q <= 16'd1) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= 16'd0;
          end else begin
            rst_cnt_q <= rst_cnt_q - 16'd1;
          end
        end
        S_LAUNCH: begin
          if (cmd_valid) cmd_err_q <= 1'b1;
          prev_pc_q  <= cpu_i_addr;
          same_cnt_q <= 16'd0;
          first_q    <= 1'b1;
          state_q    <= mode_step_q ? S_STEP : S_RUN;
        end
        S_RUN, S_STEP: begin
          if (cmd_valid && !stop_cmd) cmd_err_q <= 1'b1;
          cycle_cnt_q <= cycle_cnt_q + 32'd1;
          same_cnt_q  <= same_cnt_d;
          prev_pc_q   <= cpu_i_addr;
          first_q     <= 1'b0;
          if (stop) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
            done_cause_q <= stop_cause;
          end else if (state_q == S_STEP) begin
            remain_q <= remain_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Enable falls combinationally on the stop cycle so the core's final edge is its last advance.
  assign cpu_enable = (state_q == S_LAUNCH) || (in_exec && !stop);
  assign cpu_start  = (state_q == S_LAUNCH);
  assign cpu_reset  = reset || (state_q == S_CRST);
  assign busy       = (state_q != S_IDLE);
  assign cmd_ready  = 1'b1;
  assign done       = done_q;
  assign done_cause = done_cause_q;
  assign cmd_err    = cmd_err_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
// A small behavioural core supplies cpu_i_addr; all expected values are hand-computed.
module tb_cpu_run_ctrl;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  cpu_i_addr;
  logic        cpu_enable;
  logic        cpu_start;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic [1:0]  done_cause;
  logic        cmd_err;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int adv = 0;
  int a0;

  logic [7:0] pc;
  logic       exec;
  logic       stalled;
  logic [7:0] halt_pc;
  logic [7:0] stall_pc;
  logic       stall_en;

  cpu_run_ctrl #(.HALT_CYC(4), .RST_CYC(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cpu_i_addr (cpu_i_addr),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .done_cause (done_cause),
    .cmd_err    (cmd_err),
    .cycle_cnt  (cycle_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core model: halts by holding PC at halt_pc, one-cycle load-use stall at stall_pc.
  assign cpu_i_addr = pc;
  always @(posedge clock) begin
    if (cpu_reset) begin
      pc      <= 8'd0;
      exec    <= 1'b0;
      stalled <= 1'b0;
    end else if (exec) begin
      adv <= adv + 1;
      if (pc == halt_pc) begin
        pc <= pc;
      end else if (stall_en && pc == stall_pc && !stalled) begin
        stalled <= 1'b1;
      end else begin
        pc      <= pc + 8'd1;
        stalled <= 1'b0;
      end
      if (!cpu_enable) exec <= 1'b0;
    end else if (cpu_start && cpu_enable) begin
      exec <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
    bp_en = 1'b0; bp_addr = 8'd0;
    halt_pc = 8'd200; stall_pc = 8'd0; stall_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(cpu_enable), 32'd0);
    check("rst_start", 32'(cpu_start), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cause", 32'(done_cause), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("cmd_ready", 32'(cmd_ready), 32'd1);

    // STOP while idle is a silent no-op
    issue(2'd3, 16'd0);
    check("idle_stop_busy", 32'(busy), 32'd0);
    check("idle_stop_err", 32'(cmd_err), 32'd0);
    check("idle_stop_done", 32'(done), 32'd0);

    // STEP 3 from PC 0
    a0 = adv;
    issue(2'd2, 16'd3);
    check("s3_launch_start", 32'(cpu_start), 32'd1);
    check("s3_launch_en", 32'(cpu_enable), 32'd1);
    check("s3_launch_busy", 32'(busy), 32'd1);
    tick();
    check("s3_c1_start", 32'(cpu_start), 32'd0);
    check("s3_c1_en", 32'(cpu_enable), 32'd1);
    tick();
    check("s3_c2_en", 32'(cpu_enable), 32'd1);
    tick();
    check("s3_c3_en", 32'(cpu_enable), 32'd0);
    tick();
    check("s3_done", 32'(done), 32'd1);
    check("s3_cause", 32'(done_cause), 32'd0);
    check("s3_pc", 32'(cpu_i_addr), 32'd3);
    check("s3_cycle", cycle_cnt, 32'd3);
    check("s3_adv", 32'(adv - a0), 32'd3);
    check("s3_busy", 32'(busy), 32'd0);
    tick();
    check("s3_done_pulse", 32'(done), 32'd0);

    // STEP 0 behaves as STEP 1
    a0 = adv;
    issue(2'd2, 16'd0);
    tick();
    check("s0_c1_en", 32'(cpu_enable), 32'd0);
    tick();
    check("s0_done", 32'(done), 32'd1);
    check("s0_cause", 32'(done_cause), 32'd0);
    check("s0_pc", 32'(cpu_i_addr), 32'd4);
    check("s0_adv", 32'(adv - a0), 32'd1);
    check("s0_cycle", cycle_cnt, 32'd4);

    // RESET command, with a RUN dropped while in core reset
    issue(2'd0, 16'd0);
    check("crst1_cpu_reset", 32'(cpu_reset), 32'd1);
    check("crst1_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("crst2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("crst2_cmd_err", 32'(cmd_err), 32'd1);
    tick();
    check("crst_end_cpu_reset", 32'(cpu_reset), 32'd0);
    check("crst_end_busy", 32'(busy), 32'd0);
    check("crst_end_err", 32'(cmd_err), 32'd0);
    check("crst_end_done", 32'(done), 32'd0);
    check("crst_pc", 32'(cpu_i_addr), 32'd0);

    // Breakpoint at 5, RUN from PC 0
    bp_en = 1'b1; bp_addr = 8'd5;
    a0 = adv;
    issue(2'd1, 16'd0);
    repeat (6) tick();
    check("bp_pc_at_stop", 32'(cpu_i_addr), 32'd5);
    check("bp_en_drop", 32'(cpu_enable), 32'd0);
    tick();
    check("bp_done", 32'(done), 32'd1);
    check("bp_cause", 32'(done_cause), 32'd1);
    check("bp_pc_after", 32'(cpu_i_addr), 32'd6);
    check("bp_cycle", cycle_cnt, 32'd10);
    check("bp_adv", 32'(adv - a0), 32'd6);

    // Resume from the breakpoint PC, load-use stall at 7, HALT at 9
    bp_addr = 8'd6; halt_pc = 8'd9; stall_pc = 8'd7; stall_en = 1'b1;
    a0 = adv;
    issue(2'd1, 16'd0);
    tick();
    check("resume_c1_pc", 32'(cpu_i_addr), 32'd6);
    check("resume_c1_en", 32'(cpu_enable), 32'd1);
    repeat (7) tick();
    check("halt_c8_en", 32'(cpu_enable), 32'd1);
    tick();
    check("halt_c9_en", 32'(cpu_enable), 32'd0);
    tick();
    check("halt_done", 32'(done), 32'd1);
    check("halt_cause", 32'(done_cause), 32'd2);
    check("halt_pc", 32'(cpu_i_addr), 32'd9);
    check("halt_cycle", cycle_cnt, 32'd19);
    check("halt_adv", 32'(adv - a0), 32'd9);
    stall_en = 1'b0; halt_pc = 8'd200;

    // RUN with a dropped STEP, then STOP coinciding with a breakpoint at 12
    bp_addr = 8'd12;
    issue(2'd1, 16'd0);
    tick();
    tick();
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_count = 16'd5;
    #1;
    check("midrun_step_en", 32'(cpu_enable), 32'd1);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("midrun_cmd_err", 32'(cmd_err), 32'd1);
    check("midrun_busy", 32'(busy), 32'd1);
    check("midrun_en", 32'(cpu_enable), 32'd1);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'd3;
    #1;
    check("stop_pc", 32'(cpu_i_addr), 32'd12);
    check("stop_en", 32'(cpu_enable), 32'd0);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("stop_done", 32'(done), 32'd1);
    check("stop_cause", 32'(done_cause), 32'd3);
    check("stop_pc_after", 32'(cpu_i_addr), 32'd13);
    check("stop_cmd_err", 32'(cmd_err), 32'd0);
    check("stop_cycle", cycle_cnt, 32'd23);
    tick();
    check("stop_done_pulse", 32'(done), 32'd0);
    check("stop_cause_held", 32'(done_cause), 32'd3);

    // Asynchronous reset in the middle of STEP 10
    bp_en = 1'b0;
    issue(2'd2, 16'd10);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_en", 32'(cpu_enable), 32'd0);
    check("async_start", 32'(cpu_start), 32'd0);
    check("async_cpu_reset", 32'(cpu_reset), 32'd1);
    check("async_cycle", cycle_cnt, 32'd0);
    check("async_cause", 32'(done_cause), 32'd0);
    check("async_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("async_after_done", 32'(done), 32'd0);
    check("async_after_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
